// File: rtl/ser_par_conv_32.sv
// Serial-to-parallel converter: assembles WIDTH-bit words and strobes write.
// Define SER_PAR_MSB_FIRST_EN for MSB-first (shift-left) assembly.
module ser_par_conv_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Data_in,
    input  logic             En,
    output logic [WIDTH-1:0] Data_out,
    output logic             write
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             write_q, write_d;
    logic [WIDTH-1:0] shifted;

`ifdef SER_PAR_MSB_FIRST_EN
    assign shifted = {data_q[WIDTH-2:0], Data_in};
`else
    assign shifted = {Data_in, data_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        write_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (En) begin
                    data_d  = shifted;
                    cnt_d   = ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A started word always completes; En is not looked at here.
                data_d = shifted;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    write_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    assign Data_out = data_q;
    assign write    = write_q;

endmodule

// File: tb/tb_ser_par_conv_32.sv
// Randomized bench for ser_par_conv_32 against a bit-queue word model.
module tb_ser_par_conv_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        en  = 1'b0;
    logic [31:0] dout;
    logic        wr;

    int n_vec = 0;
    int n_err = 0;

    // model state: bits of the word in flight, in arrival order
    bit          busy = 1'b0;
    bit          q[$];
    logic [31:0] exp_data = '0;
    bit          exp_wr = 1'b0;

    ser_par_conv_32 #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .Data_in(din),
        .En(en),
        .Data_out(dout),
        .write(wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] build_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) begin
`ifdef SER_PAR_MSB_FIRST_EN
            w[31-i] = q[i];
`else
            w[i] = q[i];
`endif
        end
        return w;
    endfunction

    // apply one cycle of inputs, advance the model, check outputs
    task automatic step(input logic r, input logic e, input logic d);
        rst = r;
        en  = e;
        din = d;
        @(posedge clk);
        #1;
        exp_wr = 1'b0;
        if (r) begin
            busy = 1'b0;
            q.delete();
            exp_data = '0;
        end else if (busy || e) begin
            busy = 1'b1;
            q.push_back(d);
            if (q.size() == 32) begin
                exp_data = build_word();
                exp_wr   = 1'b1;
                busy     = 1'b0;
                q.delete();
            end
        end
        chk("write", {31'd0, wr}, {31'd0, exp_wr});
        if (exp_wr || r) chk("data", dout, exp_data);
    endtask

    logic [31:0] alt_word;

    initial begin
`ifdef SER_PAR_MSB_FIRST_EN
        alt_word = 32'hAAAA_AAAA;
`else
        alt_word = 32'h5555_5555;
`endif
        // reset with En unknown, then quiet
        step(1'b1, 1'bx, 1'b0);
        chk("rst_data", dout, 32'h0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'($urandom));

        // single word from a one-cycle pulse, alternating bits
        for (int i = 0; i < 32; i++)
            step(1'b0, i == 0, (i % 2) == 0);
        chk("alt_wr", {31'd0, wr}, 32'd1);
        chk("alt_word", dout, alt_word);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'($urandom));

        // En toggled mid-word
        for (int i = 0; i < 32; i++)
            step(1'b0, (i < 5) || (i >= 10 && i <= 12), 1'($urandom));
        chk("tog_wr", {31'd0, wr}, 32'd1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'($urandom));

        // streaming ones
        for (int i = 0; i < 96; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i % 32 == 31) chk("stream_word", dout, 32'hFFFF_FFFF);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

        // reset mid-word, restart at E20
        for (int i = 0; i < 52; i++)
            step(i == 15, (i == 0) || (i == 20), 1'($urandom));
        chk("restart_wr", {31'd0, wr}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ser_par_conv_32.md
# ser_par_conv_32

Serial-to-parallel converter that assembles a 32-bit word from a one-bit serial stream and announces each completed word with a single-cycle `write` strobe. It sits at the front of the pipeline/FIFO path and feeds a FIFO write port directly. `Data_out` is the FIFO write data and `write` is the FIFO write enable. A single-cycle `En` pulse starts a complete word. Holding `En` high streams words back-to-back with no bubble cycles.

## Interface
Parameters:
- `WIDTH`, default 32: word length in bits; must be ≥ 2.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `Data_in`  in  1: serial data bit; sampled on every edge where a shift occurs.
- `En`  in  1: start request; sampled only in IDLE.
- `Data_out`  out  WIDTH: shift register contents; holds a valid complete word while `write` = 1.
- `write`  out  1: registered one-cycle strobe meaning a complete word is present on `Data_out`.

## Operation
- Internal state:
  - FSM with states IDLE and SHIFT.
  - Bit counter `cnt`, $clog2(WIDTH) bits wide.
  - Shift register driving `Data_out`.
- IDLE:
  - If `En` = 1: shift `Data_in` into the register, set `cnt` = 1, go to SHIFT.
  - Otherwise: hold the register and counter, stay in IDLE.
- SHIFT:
  - Shift `Data_in` every cycle, regardless of `En`. Once a word has started it always completes.
  - When `cnt` = WIDTH−1, the current shift captures the last bit. On that edge:
    - `cnt` clears to 0.
    - `write` registers to 1.
    - The FSM returns to IDLE.
  - Otherwise, `cnt` increments.
- `write` is 1 for exactly one cycle per completed word. It is 0 in all other cycles.
- Default bit order is LSB-first (shift right): `Data_out` ← {`Data_in`, `Data_out`[WIDTH−1:1]}. The first received bit ends in bit 0 and the last in bit WIDTH−1.
- Back-to-back operation: with `En` = 1 in the `write` cycle, IDLE captures the first bit of the next word on the same edge that ends the `write` cycle. The stream continues with no gap.
- `Data_out` is not cleared between words. Its contents are meaningful only while `write` = 1.

## Timing
- Reset values (synchronous, on `rst` = 1 at a rising edge):
  - `Data_out` = 0 and `write` = 0.
  - FSM = IDLE and `cnt` = 0.
  - `rst` has priority over all other inputs.
- Edge numbering: E0 is the edge at which IDLE samples `En` = 1. Bits are captured on E0 through E(WIDTH−1).
- `write` is high from E(WIDTH−1) to E(WIDTH). Latency from the start edge to the strobe is WIDTH−1 edges.
- The downstream FIFO samples `Data_out` on edge E(WIDTH), which is the edge where `write` = 1.
- `Data_out` changes after E(WIDTH) only if a new word starts at E(WIDTH).
- `En` is ignored in SHIFT: raising or dropping it mid-word has no effect.
- Reset mid-word discards the partial word. No `write` is issued for it.
- `rst` in the `write` cycle clears `write` on the next edge, which is the same as normal behaviour.

## Configuration
- `SER_PAR_MSB_FIRST_EN`:
  - Defined: shift left, `Data_out` ← {`Data_out`[WIDTH−2:0], `Data_in`}. The first received bit ends in bit WIDTH−1.
  - Undefined: LSB-first shift right as described above.
- Counter, FSM and `write` timing are identical in both builds.

## Test plan
- Reset: `rst` = 1 for 1 edge with `En` = X → `Data_out` = 32'h0000_0000, `write` = 0, and no strobe while `En` = 0 for 40 cycles.
- Single word from a one-cycle `En` pulse:
  - Stimulus: `Data_in` alternates 1,0,1,0… starting with 1 at E0.
  - Response: `write` = 1 exactly once, between E31 and E32.
  - Default build: `Data_out` = 32'h5555_5555.
  - With `SER_PAR_MSB_FIRST_EN`: `Data_out` = 32'hAAAA_AAAA.
- `En` toggled mid-word: `En` = 0 at E5 and 1 at E10–E12 → still exactly one strobe at E31–E32 with the same word. No second word starts.
- Streaming: `En` held high, `Data_in` = 1 constant → `write` pulses every 32 cycles with no bubbles, and every strobe shows 32'hFFFF_FFFF.
- Reset mid-word: `rst` at E15 → no strobe for that word. A fresh `En` at E20 produces a strobe 32 edges later containing only the bits received after the restart.
